sar_adc_seq: RTL and testbench
==============================

Name: sar_adc_seq

Overview:
- Parametrised successor to the single-channel differential SAR controller.
- Drives the same comparator/dual-DAC analog front end and adds:
  - an external input-mux channel sequencer (one-shot or continuous scan);
  - a configurable sample window;
  - a valid/ready result handshake with channel tag;
  - comparator-fault detection.
- Sits between the analog SAR core (ngspice co-sim) and the digital consumer.

Parameters:
- RESOLUTION, 8, bits per conversion (>=2).
- NUM_CHANNELS, 4, analog mux inputs (>=1). CH_W = max(1, $clog2(NUM_CHANNELS)).
- SAMPLE_CYCLES, 2, cycles sample_o is held high per conversion (>=1).
- AVG_LOG2, 2, log2 of conversions averaged per channel. Used only with SAR_ADC_SEQ_AVG_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start a scan (level, sampled in IDLE)
- chan_mask_i  in  NUM_CHANNELS  channels to scan, captured at start
- continuous_i  in  1  re-scan after the last channel while high
- comp_p_i  in  1  comparator positive output (1 when vip>vin)
- comp_n_i  in  1  comparator negative output (1 when vip<vin)
- sample_o  out  1  sampling switch enable
- chan_sel_o  out  CH_W  analog mux select
- dac_p_o  out  RESOLUTION  positive DAC code
- dac_n_o  out  RESOLUTION  negative DAC code
- busy_o  out  1  state != IDLE
- result_valid_o  out  1  result available
- result_ready_i  in  1  consumer accepts result
- result_o  out  RESOLUTION  conversion result
- result_chan_o  out  CH_W  channel of result_o
- comp_err_o  out  1  one-cycle pulse: invalid comparator decision

Behaviour:
- Reset: all registers clear immediately (asynchronous), state = IDLE, every output = 0.
- Reset asserted mid-operation aborts the conversion. No partial result is emitted.
- States: IDLE, SAMPLE, CONVERT, OUTPUT. Illegal encoding goes to IDLE with DACs cleared.
- IDLE:
  - If start_i=1 and chan_mask_i!=0: capture the mask, set chan_sel to the lowest set bit, go to SAMPLE.
  - start_i with mask 0 is ignored.
  - start_i outside IDLE is ignored.
- SAMPLE:
  - sample_o=1 for exactly SAMPLE_CYCLES cycles, with dac_p/dac_n = 0.
  - Then enter CONVERT with mask = 1<<(RESOLUTION-1).
- CONVERT, one bit per cycle:
  - comp = comp_p_i & ~comp_n_i.
  - If comp: dac_p ^= mask and result |= mask. Otherwise dac_n ^= mask.
  - mask >>= 1. When mask reaches 0, go to OUTPUT.
- Comparator fault:
  - comp_p_i==comp_n_i during CONVERT is a fault.
  - The bit is decided as 0 and comp_err_o pulses that cycle.
- Latency: start accepted at cycle 0 → sample_o cycles 1..SAMPLE_CYCLES → CONVERT for RESOLUTION cycles → result_valid_o rises at cycle SAMPLE_CYCLES+RESOLUTION+1 (defaults: 11).
- OUTPUT:
  - result_valid_o=1. result_o, result_chan_o and DAC codes are held stable until result_ready_i=1 (transfer cycle).
  - On transfer, search for the next set mask bit above the current channel:
    - found → SAMPLE on that channel;
    - none found and continuous_i=1 → wrap to the lowest set bit and go to SAMPLE;
    - otherwise → IDLE.
- chan_sel_o changes only on entering SAMPLE and is stable through SAMPLE, CONVERT and OUTPUT.
- Dropping continuous_i mid-scan finishes the remaining channels of the current scan, then returns to IDLE.

Optional Feature:
- Macro SAR_ADC_SEQ_AVG_EN.
- Defined:
  - Each channel is converted 2^AVG_LOG2 times back-to-back (each with a full SAMPLE phase).
  - Results are summed in a RESOLUTION+AVG_LOG2 bit accumulator.
  - result_o = sum >> AVG_LOG2 (truncating). One handshake per channel.
  - comp_err_o is pulsed on any fault in any pass.
  - Latency per channel = 2^AVG_LOG2 × (SAMPLE_CYCLES+RESOLUTION) + 1.
- Undefined: single conversion per channel, no accumulator logic, and AVG_LOG2 is ignored.

Decomposition:
- Package sar_adc_pkg:
  - state_t enum (IDLE, SAMPLE, CONVERT, OUTPUT);
  - CH_W helper function;
  - fault-decode constant.
- Sub-module sar_chan_picker: combinational next-set-bit search with wrap flag, parametrised by NUM_CHANNELS. Inputs: captured mask and current channel. Outputs: next channel, found, wrapped.

Test Plan:
1. Comparator model with vin code 0xA5, mask 4'b0001, ready=1 → result_o=0xA5, result_chan_o=0, valid exactly at cycle 11, sample_o high cycles 1-2, then IDLE.
2. Mask 4'b1010, ready held low 3 cycles on the first result → ch1 result held stable 3 cycles, then ch3 result, then busy_o=0. chan_sel_o goes 1 then 3.
3. continuous_i=1, mask 4'b0100 → repeated ch2 results every 11 cycles. Deassert continuous_i mid-conversion → that conversion completes, then IDLE.
4. comp_p_i=comp_n_i=1 during the MSB cycle, model 0x7F otherwise → result_o=0x7F, dac_n_o bit7=1, comp_err_o high exactly one cycle.
5. rst_i asserted mid-CONVERT → all outputs 0 in the same cycle (asynchronous). After release, start_i with mask 0 keeps busy_o=0.
6. SAR_ADC_SEQ_AVG_EN, AVG_LOG2=2, model codes 100,101,102,103 → single handshake, result_o=101, valid at cycle 41.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared state type, comparator fault decode and channel-width helper
package sar_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  // Indexed by {comp_p, comp_n}: equal outputs mean the comparator made no decision.
  localparam logic [3:0] COMP_FAULT_LUT = 4'b1001;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_chan_picker.sv
// rtl/sar_chan_picker.sv - next set mask bit above the current channel, else wrap to the lowest set bit
module sar_chan_picker
  import sar_adc_pkg::*;
#(
  parameter int  NUM_CHANNELS = 4,
  localparam int CH_W         = ch_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] mask_i,
  input  logic [CH_W-1:0]         cur_i,
  output logic [CH_W-1:0]         next_o,
  output logic                    found_o,
  output logic                    wrapped_o
);

  always_comb begin
    next_o    = '0;
    found_o   = 1'b0;
    wrapped_o = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_i))) begin
        next_o  = CH_W'(i);
        found_o = 1'b1;
      end
    end
    if (!found_o) begin
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
        if (mask_i[i]) begin
          next_o    = CH_W'(i);
          wrapped_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sar_adc_seq.sv
// rtl/sar_adc_seq.sv - multi-channel SAR sequencer with result handshake; SAR_ADC_SEQ_AVG_EN adds per-channel averaging
module sar_adc_seq
  import sar_adc_pkg::*;
#(
  parameter int  RESOLUTION    = 8,
  parameter int  NUM_CHANNELS  = 4,
  parameter int  SAMPLE_CYCLES = 2,
  parameter int  AVG_LOG2      = 2,
  localparam int CH_W          = ch_width(NUM_CHANNELS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [NUM_CHANNELS-1:0] chan_mask_i,
  input  logic                    continuous_i,
  input  logic                    comp_p_i,
  input  logic                    comp_n_i,
  output logic                    sample_o,
  output logic [CH_W-1:0]         chan_sel_o,
  output logic [RESOLUTION-1:0]   dac_p_o,
  output logic [RESOLUTION-1:0]   dac_n_o,
  output logic                    busy_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic [RESOLUTION-1:0]   result_o,
  output logic [CH_W-1:0]         result_chan_o,
  output logic                    comp_err_o
);

  if (RESOLUTION < 2 || NUM_CHANNELS < 1 || SAMPLE_CYCLES < 1 || AVG_LOG2 < 0) begin : g_param_check
    $error("sar_adc_seq: parameter out of range");
  end

  localparam int                    SC_W     = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [SC_W-1:0]       SMP_LAST = SC_W'(SAMPLE_CYCLES - 1);
  localparam logic [RESOLUTION-1:0] MSB      = {1'b1, {(RESOLUTION-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [SC_W-1:0]         smp_cnt_q, smp_cnt_d;
  logic [RESOLUTION-1:0]   bit_mask_q, bit_mask_d;
  logic [RESOLUTION-1:0]   dac_p_q, dac_p_d;
  logic [RESOLUTION-1:0]   dac_n_q, dac_n_d;
  logic [NUM_CHANNELS-1:0] cmask_q, cmask_d;
  logic [CH_W-1:0]         chan_q, chan_d;

  logic [CH_W-1:0] next_ch, first_ch;
  logic            next_found, next_wrap, first_found, first_wrap;
  logic            comp_bit, comp_fault, enter_smp;

`ifdef SAR_ADC_SEQ_AVG_EN
  localparam int                ACC_W     = RESOLUTION + AVG_LOG2;
  localparam int                PASS_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q, acc_d, pass_sum;
  logic [PASS_W-1:0] pass_q, pass_d;
`endif

  assign comp_fault = COMP_FAULT_LUT[{comp_p_i, comp_n_i}];
  assign comp_bit   = comp_p_i & ~comp_n_i;

  sar_chan_picker #(.NUM_CHANNELS(NUM_CHANNELS)) u_next_pick (
    .mask_i    (cmask_q),
    .cur_i     (chan_q),
    .next_o    (next_ch),
    .found_o   (next_found),
    .wrapped_o (next_wrap)
  );

  // Searching above the top channel always wraps, yielding the lowest set bit of the new mask.
  sar_chan_picker #(.NUM_CHANNELS(NUM_CHANNELS)) u_first_pick (
    .mask_i    (chan_mask_i),
    .cur_i     (CH_W'(NUM_CHANNELS - 1)),
    .next_o    (first_ch),
    .found_o   (first_found),
    .wrapped_o (first_wrap)
  );

  always_comb begin
    state_d    = state_q;
    smp_cnt_d  = smp_cnt_q;
    bit_mask_d = bit_mask_q;
    dac_p_d    = dac_p_q;
    dac_n_d    = dac_n_q;
    cmask_d    = cmask_q;
    chan_d     = chan_q;
    enter_smp  = 1'b0;
`ifdef SAR_ADC_SEQ_AVG_EN
    acc_d      = acc_q;
    pass_d     = pass_q;
    pass_sum   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i && (first_found || first_wrap)) begin
          cmask_d   = chan_mask_i;
          chan_d    = first_ch;
          enter_smp = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (smp_cnt_q == SMP_LAST) begin
          state_d    = ST_CONVERT;
          bit_mask_d = MSB;
        end else begin
          smp_cnt_d = smp_cnt_q + 1'b1;
        end
      end
      ST_CONVERT: begin
        if (comp_bit) dac_p_d = dac_p_q ^ bit_mask_q;
        else          dac_n_d = dac_n_q ^ bit_mask_q;
        bit_mask_d = bit_mask_q >> 1;
        if (bit_mask_q[0]) begin
`ifdef SAR_ADC_SEQ_AVG_EN
          pass_sum = acc_q + ACC_W'(dac_p_d);
          acc_d    = pass_sum;
          if (pass_q == PASS_LAST) begin
            state_d = ST_OUTPUT;
          end else begin
            pass_d    = pass_q + 1'b1;
            dac_p_d   = '0;
            dac_n_d   = '0;
            smp_cnt_d = '0;
            state_d   = ST_SAMPLE;
          end
`else
          state_d = ST_OUTPUT;
`endif
        end
      end
      ST_OUTPUT: begin
        if (result_ready_i) begin
          if (next_found || (continuous_i && next_wrap)) begin
            chan_d    = next_ch;
            enter_smp = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        dac_p_d = '0;
        dac_n_d = '0;
      end
    endcase
    if (enter_smp) begin
      state_d   = ST_SAMPLE;
      smp_cnt_d = '0;
      dac_p_d   = '0;
      dac_n_d   = '0;
`ifdef SAR_ADC_SEQ_AVG_EN
      acc_d     = '0;
      pass_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      smp_cnt_q  <= '0;
      bit_mask_q <= '0;
      dac_p_q    <= '0;
      dac_n_q    <= '0;
      cmask_q    <= '0;
      chan_q     <= '0;
`ifdef SAR_ADC_SEQ_AVG_EN
      acc_q      <= '0;
      pass_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      bit_mask_q <= bit_mask_d;
      dac_p_q    <= dac_p_d;
      dac_n_q    <= dac_n_d;
      cmask_q    <= cmask_d;
      chan_q     <= chan_d;
`ifdef SAR_ADC_SEQ_AVG_EN
      acc_q      <= acc_d;
      pass_q     <= pass_d;
`endif
    end
  end

  assign sample_o       = (state_q == ST_SAMPLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign result_valid_o = (state_q == ST_OUTPUT);
  assign chan_sel_o     = chan_q;
  assign result_chan_o  = chan_q;
  assign dac_p_o        = dac_p_q;
  assign dac_n_o        = dac_n_q;
  assign comp_err_o     = (state_q == ST_CONVERT) && comp_fault;

`ifdef SAR_ADC_SEQ_AVG_EN
  assign result_o = acc_q[ACC_W-1:AVG_LOG2];
`else
  // The positive DAC collects exactly the decided 1-bits, so it already is the result.
  assign result_o = dac_p_q;
`endif

endmodule

// File: tb/tb_sar_adc_seq.sv
// tb/tb_sar_adc_seq.sv - scoreboard bench for sar_adc_seq with a behavioural comparator model
module tb_sar_adc_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] chan_mask_i = 4'd0;
  logic       continuous_i = 1'b0;
  logic       comp_p_i = 1'b0;
  logic       comp_n_i = 1'b0;
  logic       result_ready_i = 1'b0;
  logic       sample_o, busy_o, result_valid_o, comp_err_o;
  logic [1:0] chan_sel_o, result_chan_o;
  logic [7:0] dac_p_o, dac_n_o, result_o;

  sar_adc_seq #(
    .RESOLUTION(8), .NUM_CHANNELS(4), .SAMPLE_CYCLES(2), .AVG_LOG2(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .chan_mask_i(chan_mask_i),
    .continuous_i(continuous_i), .comp_p_i(comp_p_i), .comp_n_i(comp_n_i),
    .sample_o(sample_o), .chan_sel_o(chan_sel_o), .dac_p_o(dac_p_o), .dac_n_o(dac_n_o),
    .busy_o(busy_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o), .result_chan_o(result_chan_o), .comp_err_o(comp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic [1:0] ch;
    int         vcyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] vin_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         err_cnt = 0;
  int         err_cyc = -1;
  int         fault_pos = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_res(input logic [7:0] res, input logic [1:0] ch, input int vcyc);
    exp_t e;
    e.res = res;
    e.ch = ch;
    e.vcyc = vcyc;
    exp_q.push_back(e);
  endtask

  task automatic start_scan(input logic [3:0] m, input logic cont);
    chan_mask_i = m;
    continuous_i = cont;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Comparator model: one vin code per conversion, MSB first, optional forced fault at one bit.
  initial begin
    int         pos;
    logic       smp_seen;
    logic [7:0] cur_v;
    pos = -1;
    smp_seen = 1'b0;
    cur_v = 8'd0;
    forever begin
      @(posedge clk_i);
      #2;
      if (sample_o) begin
        if (!smp_seen) begin
          cur_v = (vin_q.size() > 0) ? vin_q.pop_front() : 8'd0;
          smp_seen = 1'b1;
        end
        pos = 7;
        comp_p_i = 1'b0;
        comp_n_i = 1'b0;
      end else begin
        smp_seen = 1'b0;
        if (busy_o && !result_valid_o && pos >= 0) begin
          if (pos == fault_pos) begin
            comp_p_i = 1'b1;
            comp_n_i = 1'b1;
          end else begin
            comp_p_i = cur_v[pos];
            comp_n_i = ~cur_v[pos];
          end
          pos--;
        end else begin
          comp_p_i = 1'b0;
          comp_n_i = 1'b0;
        end
      end
    end
  end

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_res = 8'd0;
  logic [1:0] prev_ch = 2'd0;
  int         rise_cyc = -1;

  always @(negedge clk_i) begin
    exp_t e;
    if (comp_err_o) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (result_valid_o && !prev_valid) rise_cyc = cyc;
    if (result_valid_o && prev_valid && !prev_ready) begin
      check("hold_result", 32'(result_o), 32'(prev_res));
      check("hold_chan", 32'(result_chan_o), 32'(prev_ch));
    end
    if (result_valid_o && result_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got 0x%0h on ch %0d with nothing expected", result_o, result_chan_o);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(result_o), 32'(e.res));
        check("result_chan", 32'(result_chan_o), 32'(e.ch));
        check("valid_cycle", 32'(rise_cyc), 32'(e.vcyc));
      end
    end
    prev_valid = result_valid_o;
    prev_ready = result_ready_i;
    prev_res = result_o;
    prev_ch = result_chan_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (2) tick();
    check("reset_outputs", {sample_o, busy_o, result_valid_o, comp_err_o, chan_sel_o, result_chan_o,
                            dac_p_o, dac_n_o, result_o}, 32'd0);
    rst_i = 1'b0;
    tick();

`ifdef SAR_ADC_SEQ_AVG_EN
    result_ready_i = 1'b1;
    err_cnt = 0;
    vin_q.push_back(8'd100);
    vin_q.push_back(8'd101);
    vin_q.push_back(8'd102);
    vin_q.push_back(8'd103);
    expect_res(8'd101, 2'd0, cyc + 41);
    start_scan(4'b0001, 1'b0);
    for (int c = 1; c <= 41; c++) begin
      check("avg_sample_o", 32'(sample_o), 32'((c <= 40) && (((c - 1) % 10) < 2)));
      tick();
    end
    check("avg_idle_after", 32'(busy_o), 32'd0);
    check("avg_no_fault", 32'(err_cnt), 32'd0);
`else
    // one channel, immediate accept
    result_ready_i = 1'b1;
    vin_q.push_back(8'hA5);
    expect_res(8'hA5, 2'd0, cyc + 11);
    start_scan(4'b0001, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      check("t1_sample_o", 32'(sample_o), 32'(c <= 2));
      if (c == 12) check("t1_idle", 32'(busy_o), 32'd0);
      tick();
    end

    // two channels, back-pressure on the first result
    result_ready_i = 1'b0;
    vin_q.push_back(8'h5A);
    vin_q.push_back(8'hC3);
    expect_res(8'h5A, 2'd1, cyc + 11);
    expect_res(8'hC3, 2'd3, cyc + 25);
    start_scan(4'b1010, 1'b0);
    check("t2_chan_first", 32'(chan_sel_o), 32'd1);
    repeat (13) tick();
    check("t2_still_valid", 32'(result_valid_o), 32'd1);
    result_ready_i = 1'b1;
    tick();
    check("t2_chan_second", 32'(chan_sel_o), 32'd3);
    repeat (11) tick();
    check("t2_idle", 32'(busy_o), 32'd0);

    // continuous scan, dropped during the third conversion
    base = cyc;
    for (int k = 1; k <= 3; k++) begin
      vin_q.push_back(8'h3C);
      expect_res(8'h3C, 2'd2, base + 11 * k);
    end
    start_scan(4'b0100, 1'b1);
    check("t3_chan", 32'(chan_sel_o), 32'd2);
    repeat (26) tick();
    continuous_i = 1'b0;
    repeat (7) tick();
    check("t3_idle", 32'(busy_o), 32'd0);

    // comparator fault on the MSB
    fault_pos = 7;
    err_cnt = 0;
    vin_q.push_back(8'h7F);
    base = cyc;
    expect_res(8'h7F, 2'd0, base + 11);
    start_scan(4'b0001, 1'b0);
    repeat (10) tick();
    check("t4_dac_n", 32'(dac_n_o), 32'h80);
    check("t4_dac_p", 32'(dac_p_o), 32'h7F);
    tick();
    check("t4_err_count", 32'(err_cnt), 32'd1);
    check("t4_err_cycle", 32'(err_cyc), 32'(base + 3));
    fault_pos = -1;

    // asynchronous reset mid-conversion, then a start with an empty mask
    vin_q.push_back(8'h55);
    start_scan(4'b0010, 1'b0);
    repeat (5) tick();
    check("t5_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("t5_async_reset", {sample_o, busy_o, result_valid_o, comp_err_o, chan_sel_o, result_chan_o,
                             dac_p_o, dac_n_o, result_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    chan_mask_i = 4'b0000;
    start_i = 1'b1;
    repeat (4) begin
      tick();
      check("t5_empty_mask", 32'(busy_o), 32'd0);
    end
    start_i = 1'b0;
`endif

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
